// File: rtl/lcd_bus_rx.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_rx
// Purpose  : Receive side of an 8080-style parallel LCD write bus. Writes are
//            committed on the rising edge of lcd_wr_n, observed through a
//            two-flop synchronizer, and queued as {rs, d} words in a small
//            FIFO that has a valid/ready head. A free-running frame-mark
//            pulse generator is included.
// Ports    : clk, rst_n       - clock (rising edge), async active-low reset
//            lcd_d/rs/wr_n    - bus inputs from the write-side PHY
//            lcd_fmark        - registered frame-mark pulse
//            rx_data/rx_rs    - head word of the receive FIFO (0 when empty)
//            rx_valid/ready   - head handshake; transfer on valid & ready
//            rx_overflow      - sticky drop flag, cleared by ovf_clr
//            fmark_en         - frame-mark generator enable
// Params   : FIFO_DEPTH (power of 2, >= 2), FMARK_PERIOD (>= 2),
//            FMARK_WIDTH (1 .. FMARK_PERIOD-1)
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bus_rx #(
    parameter int FIFO_DEPTH   = 4,
    parameter int FMARK_PERIOD = 1024,
    parameter int FMARK_WIDTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] lcd_d,
    input  logic       lcd_rs,
    input  logic       lcd_wr_n,
    output logic       lcd_fmark,
    output logic [7:0] rx_data,
    output logic       rx_rs,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overflow,
    input  logic       ovf_clr,
    input  logic       fmark_en
);

    localparam int              c_AW      = $clog2(FIFO_DEPTH);
    localparam int              c_FW      = $clog2(FMARK_PERIOD);
    localparam logic [c_AW:0]   c_DEPTH   = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_FW-1:0] c_FM_LAST = c_FW'(FMARK_PERIOD - 1);
    localparam logic [c_FW-1:0] c_FM_HIGH = c_FW'(FMARK_WIDTH);

    // ------------------------------------------------------------------
    // Bus synchronizer and write-edge detection
    // ------------------------------------------------------------------
    logic       r_wr_s1, r_wr_s2, r_wr_prev;
    logic [7:0] r_d_s1, r_d_s2;
    logic       r_rs_s1, r_rs_s2;
    logic       w_wr_rise;
    logic       r_cap_vld;
    logic [8:0] r_cap_word;

    // wr_n stages reset to the idle (high) level so that leaving reset can
    // never look like a low-to-high strobe transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_s1   <= 1'b1;
            r_wr_s2   <= 1'b1;
            r_wr_prev <= 1'b1;
            r_d_s1    <= '0;
            r_d_s2    <= '0;
            r_rs_s1   <= 1'b0;
            r_rs_s2   <= 1'b0;
        end else begin
            r_wr_s1   <= lcd_wr_n;
            r_wr_s2   <= r_wr_s1;
            r_wr_prev <= r_wr_s2;
            r_d_s1    <= lcd_d;
            r_d_s2    <= r_d_s1;
            r_rs_s1   <= lcd_rs;
            r_rs_s2   <= r_rs_s1;
        end
    end

    assign w_wr_rise = r_wr_s2 & ~r_wr_prev;

    // Data is taken from the same synchronizer stage that shows wr_n high,
    // which is why the sender must hold d/rs one clock past the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_vld  <= 1'b0;
            r_cap_word <= '0;
        end else begin
            r_cap_vld <= w_wr_rise;
            if (w_wr_rise) begin
                r_cap_word <= {r_rs_s2, r_d_s2};
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [8:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_ovf;
    logic            w_full, w_pop, w_push, w_drop;
    logic [8:0]      w_head;

    assign rx_valid = (r_count != '0);
    assign w_full   = (r_count == c_DEPTH);
    // Pop is qualified by rx_valid, so push+pop on an empty FIFO is a push.
    assign w_pop    = rx_valid & rx_ready;
    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    assign w_push   = r_cap_vld & (~w_full | w_pop);
    assign w_drop   = r_cap_vld & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_cap_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign rx_overflow = r_ovf;

    // Head word is masked while empty so the outputs read 0 out of reset
    // without having to reset the storage array.
    assign w_head  = rx_valid ? r_mem[r_rd_ptr] : 9'd0;
    assign rx_rs   = w_head[8];
    assign rx_data = w_head[7:0];

    // ------------------------------------------------------------------
    // Frame-mark generator
    // ------------------------------------------------------------------
    logic [c_FW-1:0] r_fm_cnt;
    logic            r_fmark;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fm_cnt <= '0;
            r_fmark  <= 1'b0;
        end else begin
            r_fmark <= (r_fm_cnt < c_FM_HIGH) & fmark_en;
            if (!fmark_en || r_fm_cnt == c_FM_LAST) begin
                r_fm_cnt <= '0;
            end else begin
                r_fm_cnt <= r_fm_cnt + c_FW'(1);
            end
        end
    end

    assign lcd_fmark = r_fmark;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_rx
// Purpose  : Self-checking bench for lcd_bus_rx. A transaction-level model
//            (queue of words, write-commit time + fixed latency, overflow
//            flag, frame-mark phase arithmetic) predicts every output after
//            every clock edge; directed scenarios are followed by a random
//            traffic phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_rx;

    localparam int DEPTH  = 4;
    localparam int PERIOD = 16;
    localparam int WIDTH  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] lcd_d = 8'h00;
    logic       lcd_rs = 1'b0;
    logic       lcd_wr_n = 1'b1;
    logic       lcd_fmark;
    logic [7:0] rx_data;
    logic       rx_rs;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overflow;
    logic       ovf_clr = 1'b0;
    logic       fmark_en = 1'b0;

    lcd_bus_rx #(
        .FIFO_DEPTH   (DEPTH),
        .FMARK_PERIOD (PERIOD),
        .FMARK_WIDTH  (WIDTH)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lcd_d       (lcd_d),
        .lcd_rs      (lcd_rs),
        .lcd_wr_n    (lcd_wr_n),
        .lcd_fmark   (lcd_fmark),
        .rx_data     (rx_data),
        .rx_rs       (rx_rs),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_overflow (rx_overflow),
        .ovf_clr     (ovf_clr),
        .fmark_en    (fmark_en)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [8:0] word;
        int         due;
    } pend_t;

    logic [8:0] mq[$];      // words visible in the receive queue
    pend_t      pend[$];    // committed writes not yet visible
    logic       m_ovf     = 1'b0;
    logic       m_fmark   = 1'b0;
    logic       m_prev_wr = 1'b1;
    int         m_run     = 0;
    int         edge_n    = 0;

    always @(posedge clk) begin
        logic       s_rst, s_wr, s_rs, s_ready, s_clr, s_en, v_pre, popped, drop;
        logic [7:0] s_d;
        pend_t      p;
        s_rst   = rst_n;
        s_wr    = lcd_wr_n;
        s_d     = lcd_d;
        s_rs    = lcd_rs;
        s_ready = rx_ready;
        s_clr   = ovf_clr;
        s_en    = fmark_en;
        v_pre   = (mq.size() > 0);
        #1;
        if (!s_rst) begin
            mq.delete();
            pend.delete();
            m_ovf     = 1'b0;
            m_fmark   = 1'b0;
            m_prev_wr = 1'b1;
            m_run     = 0;
        end else begin
            edge_n++;
            popped = v_pre && s_ready;
            if (popped) void'(mq.pop_front());
            drop = 1'b0;
            while (pend.size() > 0 && pend[0].due == edge_n) begin
                if (mq.size() < DEPTH) mq.push_back(pend[0].word);
                else drop = 1'b1;
                void'(pend.pop_front());
            end
            if (drop) m_ovf = 1'b1;
            else if (s_clr) m_ovf = 1'b0;
            // A write is committed when wr_n is first seen high after low;
            // it becomes visible three edges after that first high sample.
            if (s_wr && !m_prev_wr) begin
                p.word = {s_rs, s_d};
                p.due  = edge_n + 3;
                pend.push_back(p);
            end
            m_prev_wr = s_wr;
            m_fmark   = s_en && ((m_run % PERIOD) < WIDTH);
            m_run     = s_en ? m_run + 1 : 0;
        end
        check_val("valid", 32'(rx_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) check_val("head", 32'({rx_rs, rx_data}), 32'(mq[0]));
        check_val("overflow", 32'(rx_overflow), 32'(m_ovf));
        check_val("fmark", 32'(lcd_fmark), 32'(m_fmark));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic bus_write(input logic [7:0] d, input logic rs, input int gap);
        @(negedge clk);
        lcd_d    = d;
        lcd_rs   = rs;
        lcd_wr_n = 1'b0;
        @(negedge clk);
        lcd_wr_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        rx_ready = 1'b1;
        while ((mq.size() != 0 || pend.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_val(tag, 32'(rx_valid), 0);
        rx_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        logic seen;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_valid", 32'(rx_valid), 0);
        check_val("rst_data", 32'({rx_rs, rx_data}), 0);
        check_val("rst_ovf", 32'(rx_overflow), 0);
        check_val("rst_fmark", 32'(lcd_fmark), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single write, latency tracked edge by edge by the model
        bus_write(8'hA5, 1'b1, 6);
        check_val("single_head", 32'({rx_rs, rx_data}), 32'(9'h1A5));
        drain("single_drain");

        // Overflow: six back-to-back writes, nothing consumed
        for (int i = 1; i <= 6; i++) bus_write(8'(i), 1'(i & 1), 0);
        repeat (6) @(negedge clk);
        check_val("ovf_set", 32'(rx_overflow), 1);
        check_val("ovf_head", 32'(rx_data), 32'h01);
        drain("ovf_drain");
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check_val("ovf_cleared", 32'(rx_overflow), 0);

        // Full FIFO with pop on the push edge
        for (int i = 0; i < 4; i++) bus_write(8'h10 + 8'(i), 1'b0, 0);
        @(negedge clk);
        lcd_d = 8'h14; lcd_rs = 1'b1; lcd_wr_n = 1'b0;
        @(negedge clk);
        lcd_wr_n = 1'b1;
        repeat (3) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("pushpop_ovf", 32'(rx_overflow), 0);
        drain("pushpop_drain");

        // Clear coinciding with a drop, then clear alone
        for (int i = 0; i < 5; i++) bus_write(8'h20 + 8'(i), 1'b0, 0);
        @(negedge clk);
        lcd_d = 8'h2F; lcd_wr_n = 1'b0;
        @(negedge clk);
        lcd_wr_n = 1'b1;
        repeat (3) @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        check_val("clr_vs_drop", 32'(rx_overflow), 1);
        @(negedge clk);
        ovf_clr = 1'b0;
        check_val("clr_alone", 32'(rx_overflow), 0);
        drain("clr_drain");

        // Frame mark: count highs over two full periods
        fmark_en = 1'b1;
        repeat (5) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(posedge clk);
            #1;
            cnt += int'(lcd_fmark);
        end
        check_val("fmark_count", 32'(cnt), 32'(2 * WIDTH));
        seen = 1'b0;
        for (int i = 0; i < 2 * PERIOD && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = lcd_fmark;
        end
        check_val("fmark_seen", 32'(seen), 1);
        fmark_en = 1'b0;
        @(posedge clk);
        #1;
        check_val("fmark_drop", 32'(lcd_fmark), 0);

        // Random traffic
        for (int it = 0; it < 200; it++) begin
            @(negedge clk);
            rx_ready = 1'($urandom_range(0, 2) != 0);
            ovf_clr  = 1'($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) fmark_en = ~fmark_en;
            if ($urandom_range(0, 2) != 0)
                bus_write(8'($urandom), 1'($urandom), $urandom_range(0, 2));
        end
        ovf_clr = 1'b0;
        drain("rand_drain");

        // Reset with three words stored
        fmark_en = 1'b1;
        for (int i = 0; i < 3; i++) bus_write(8'h30 + 8'(i), 1'b1, 0);
        repeat (5) @(negedge clk);
        check_val("pre_rst_valid", 32'(rx_valid), 1);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(rx_valid), 0);
        check_val("async_rst_fmark", 32'(lcd_fmark), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_val("post_rst_empty", 32'(rx_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_bus_rx.md
LCD_BUS_RX -- requirements
Module: lcd_bus_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO depth in words; must be a power of 2 and at least 2.
REQ-002 SHALL have parameter FMARK_PERIOD, default 1024: frame-mark period in clk cycles; must be at least 2.
REQ-003 SHALL have parameter FMARK_WIDTH, default 4: frame-mark high time in clk cycles; must satisfy 1 <= FMARK_WIDTH < FMARK_PERIOD.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port lcd_d, input, 8 bits: parallel bus data from the write-side PHY.
REQ-007 SHALL have port lcd_rs, input, 1 bit: register select; 0 = command, 1 = data.
REQ-008 SHALL have port lcd_wr_n, input, 1 bit: write strobe, active-low; a write is committed on its rising edge.
REQ-009 SHALL have port lcd_fmark, output, 1 bit: generated frame-mark pulse, registered.
REQ-010 SHALL have port rx_data, output, 8 bits: captured byte at the FIFO head.
REQ-011 SHALL have port rx_rs, output, 1 bit: captured rs at the FIFO head.
REQ-012 SHALL have port rx_valid, output, 1 bit: FIFO non-empty.
REQ-013 SHALL have port rx_ready, input, 1 bit: consumer accepts the head word.
REQ-014 SHALL have port rx_overflow, output, 1 bit: sticky flag, set when a write is dropped.
REQ-015 SHALL have port ovf_clr, input, 1 bit: clears rx_overflow.
REQ-016 SHALL have port fmark_en, input, 1 bit: enables the frame-mark generator.

Function
REQ-017 SHALL pass lcd_wr_n, lcd_rs and lcd_d through a 2-flop synchronizer; the synchronized copies feed a third register stage (prev) used for edge detection.
REQ-018 SHALL detect a write when synchronized wr_n = 1 and its prev stage = 0, and SHALL capture the synchronized d/rs from that same stage.
REQ-019 SHALL accept a minimum write cycle of wr_n low for 1 clk then high for 1 clk (2-clk back-to-back writes); d/rs must be held by the sender for at least 1 clk after wr_n rises.
REQ-020 SHALL NOT support the full-speed DDR strobe form (wr_n low for half a clk); behaviour on that form is undefined.
REQ-021 SHALL write the captured {rs, d} into the FIFO on the cycle after detection.
REQ-022 SHALL give a latency, with the FIFO empty, of exactly 3 clk edges from the first edge that samples lcd_wr_n high to rx_valid = 1.
REQ-023 SHALL treat a transfer as occurring on any cycle with rx_valid & rx_ready; rx_data/rx_rs advance to the next word on the following cycle.
REQ-024 SHALL keep rx_data/rx_rs stable while rx_valid = 1 and rx_ready = 0.
REQ-025 SHALL preserve FIFO order: words are delivered in bus-write order with no duplication.
REQ-026 SHALL, on a push into a full FIFO with no same-cycle pop, drop the new word, leave the stored contents unchanged and set rx_overflow.
REQ-027 SHALL, on a push into a full FIFO with a same-cycle pop, accept the word and leave rx_overflow unchanged.
REQ-028 SHALL, on a push and pop of an empty FIFO in the same cycle, take no pop and accept the push.
REQ-029 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer bit or an occupancy counter.
REQ-030 SHALL clear rx_overflow when ovf_clr = 1; if an overflow occurs in the same cycle as ovf_clr, the set wins.
REQ-031 SHALL run a frame-mark counter 0..FMARK_PERIOD-1 that wraps to 0 while fmark_en = 1.
REQ-032 SHALL drive lcd_fmark <= (counter < FMARK_WIDTH) & fmark_en.
REQ-033 SHALL, while fmark_en = 0, hold the counter at 0; lcd_fmark falls on the next clk edge.
REQ-034 SHALL, on fmark_en rising, raise lcd_fmark on the next edge (counter starts at 0).

Reset
REQ-035 SHALL, on rst_n = 0, asynchronously clear the FIFO pointers/occupancy, rx_valid, rx_overflow, lcd_fmark and the fmark counter.
REQ-036 SHALL, on rst_n = 0, set rx_data and rx_rs to 0.
REQ-037 SHALL reset the wr_n synchronizer and prev stages to 1 (bus idle), so reset release alone never produces a write.
REQ-038 SHALL make reset mid-operation discard all stored words; no partial write is committed after release unless a full low-to-high wr_n transition is observed.

Verification
REQ-039 SHALL cover single write: d=0xA5, rs=1, wr_n low 1 clk -> rx_valid exactly 3 edges after wr_n is sampled high; rx_data=0xA5, rx_rs=1; one word only.
REQ-040 SHALL cover overflow: 6 back-to-back 2-clk writes 0x01..0x06, rx_ready=0, depth 4 -> rx_overflow=1; drain gives 0x01..0x04 then rx_valid=0.
REQ-041 SHALL cover full with simultaneous push and pop: rx_ready=1 on the push cycle -> rx_overflow stays 0; all words delivered in order.
REQ-042 SHALL cover ovf_clr coinciding with a new drop -> rx_overflow stays 1; ovf_clr alone next cycle -> 0.
REQ-043 SHALL cover frame mark: FMARK_PERIOD=16, FMARK_WIDTH=2 -> lcd_fmark high 2 of every 16 cycles; fmark_en dropped mid-pulse -> 0 on next edge.
REQ-044 SHALL cover reset: rst_n asserted with 3 words stored -> rx_valid=0 immediately; after release with lcd_wr_n held high -> no word.
